// File: rtl/proc_hier_top.sv
// proc_hier_top: 16-bit, 8-register, two-stage (fetch / execute-commit)
// processor with internal instruction and data memories and a per-cycle
// commit trace. Memory depths are assumed to be powers of two.
// Optional feature: define INST_COUNT_EN to add the inst_count output.
module proc_hier_top #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prog_we,
  input  logic        prog_sel,
  input  logic [15:0] prog_addr,
  input  logic [15:0] prog_data,
  output logic [15:0] pc,
  output logic [15:0] inst,
  output logic        reg_write,
  output logic [2:0]  write_register,
  output logic [15:0] write_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_data_in,
  output logic [15:0] mem_data_out,
  output logic        halt,
  output logic        dcache_hit,
  output logic        icache_hit,
  output logic        dcache_req,
  output logic        icache_req,
`ifdef INST_COUNT_EN
  output logic [31:0] inst_count,
`endif
  output logic [31:0] cycle_count
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_XOR  = 4'h4,
    OP_ADDI = 4'h5,
    OP_LD   = 4'h6,
    OP_ST   = 4'h7,
    OP_BEQZ = 4'h8,
    OP_J    = 4'h9,
    OP_HALT = 4'hF
  } opcode_e;

  logic [15:0] r_imem [IMEM_DEPTH];
  logic [15:0] r_dmem [DMEM_DEPTH];
  logic [15:0] r_regs [8];

  logic [15:0] r_fpc;
  logic [15:0] r_pc;
  logic [15:0] r_inst;
  logic        r_halt;
  logic [31:0] r_cycle;

  opcode_e     w_op;
  logic [2:0]  w_rd, w_rs, w_rt;
  logic [15:0] w_imm6, w_imm9;
  logic [15:0] w_rd_val, w_rs_val, w_rt_val;
  logic [15:0] w_ea;
  logic [15:0] w_dmem_rdata;
  logic [15:0] w_fetch_word;
  logic        w_we;
  logic [15:0] w_wdata;
  logic        w_mr, w_mw;
  logic [15:0] w_maddr, w_mdin, w_mdout;
  logic        w_taken;
  logic [15:0] w_target;
  logic        w_is_halt;
  logic        w_halt;
  logic        w_unused;

  assign w_op     = opcode_e'(r_inst[15:12]);
  assign w_rd     = r_inst[11:9];
  assign w_rs     = r_inst[8:6];
  assign w_rt     = r_inst[5:3];
  assign w_imm6   = {{10{r_inst[5]}}, r_inst[5:0]};
  assign w_imm9   = {{7{r_inst[8]}}, r_inst[8:0]};
  assign w_rd_val = r_regs[w_rd];
  assign w_rs_val = r_regs[w_rs];
  assign w_rt_val = r_regs[w_rt];
  assign w_ea     = w_rs_val + w_imm6;
  assign w_target = r_pc + 16'd1 + w_imm9;

  assign w_dmem_rdata = r_dmem[w_ea[DAW-1:0]];
  assign w_fetch_word = r_imem[r_fpc[IAW-1:0]];

  assign w_halt   = r_halt | w_is_halt;
  assign w_unused = ^prog_addr;

  // Execute-stage decode: trace fields, write-back value and branch resolution.
  always_comb begin
    w_we      = 1'b0;
    w_wdata   = '0;
    w_mr      = 1'b0;
    w_mw      = 1'b0;
    w_maddr   = '0;
    w_mdin    = '0;
    w_mdout   = '0;
    w_taken   = 1'b0;
    w_is_halt = 1'b0;
    case (w_op)
      OP_ADD:  begin w_we = 1'b1; w_wdata = w_rs_val + w_rt_val; end
      OP_SUB:  begin w_we = 1'b1; w_wdata = w_rs_val - w_rt_val; end
      OP_AND:  begin w_we = 1'b1; w_wdata = w_rs_val & w_rt_val; end
      OP_XOR:  begin w_we = 1'b1; w_wdata = w_rs_val ^ w_rt_val; end
      OP_ADDI: begin w_we = 1'b1; w_wdata = w_ea; end
      OP_LD: begin
        w_we    = 1'b1;
        w_wdata = w_dmem_rdata;
        w_mr    = 1'b1;
        w_maddr = w_ea;
        w_mdout = w_dmem_rdata;
      end
      OP_ST: begin
        w_mw    = 1'b1;
        w_maddr = w_ea;
        w_mdin  = w_rd_val;
      end
      OP_BEQZ: w_taken = (w_rd_val == 16'h0000);
      OP_J:    w_taken = 1'b1;
      OP_HALT: w_is_halt = 1'b1;
      default: ;
    endcase
  end

  // Instruction memory load port.
  always_ff @(posedge clk) begin
    if (prog_we && !prog_sel)
      r_imem[prog_addr[IAW-1:0]] <= prog_data;
  end

  // Data memory: committed stores, with the load port taking priority.
  always_ff @(posedge clk) begin
    if (rst_n && w_mw && !w_halt)
      r_dmem[w_maddr[DAW-1:0]] <= w_mdin;
    if (prog_we && prog_sel)
      r_dmem[prog_addr[DAW-1:0]] <= prog_data;
  end

  // Register file write-back; read combinationally next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++)
        r_regs[i] <= '0;
    end else if (w_we && !w_halt) begin
      r_regs[w_rd] <= w_wdata;
    end
  end

  // Fetch/execute pipeline registers, sticky halt and cycle counter.
  // A taken branch squashes the fetched word into a NOP bubble whose
  // pc is target-1, so the trace stays contiguous into the target.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fpc   <= '0;
      r_pc    <= '0;
      r_inst  <= '0;
      r_halt  <= 1'b0;
      r_cycle <= '0;
    end else if (w_halt) begin
      r_halt <= 1'b1;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_taken) begin
        r_fpc  <= w_target;
        r_inst <= '0;
        r_pc   <= w_target - 16'd1;
      end else begin
        r_fpc  <= r_fpc + 16'd1;
        r_inst <= w_fetch_word;
        r_pc   <= r_fpc;
      end
    end
  end

`ifdef INST_COUNT_EN
  logic [31:0] r_icount;

  // Committed-instruction counter; HALT counts only on its first cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_icount <= '0;
    else if ((w_is_halt && !r_halt) || w_we || w_mw)
      r_icount <= r_icount + 32'd1;
  end

  assign inst_count = r_icount;
`endif

  assign pc             = r_pc;
  assign inst           = r_inst;
  assign reg_write      = w_we;
  assign write_register = w_we ? w_rd : 3'd0;
  assign write_data     = w_wdata;
  assign mem_read       = w_mr;
  assign mem_write      = w_mw;
  assign mem_address    = w_maddr;
  assign mem_data_in    = w_mdin;
  assign mem_data_out   = w_mdout;
  assign halt           = w_halt;
  assign dcache_hit     = 1'b0;
  assign icache_hit     = 1'b0;
  assign dcache_req     = 1'b0;
  assign icache_req     = 1'b0;
  assign cycle_count    = r_cycle;

endmodule

// File: tb/tb_proc_hier_top.sv
// Directed bench for proc_hier_top: loads small programs under reset,
// then steps cycle by cycle comparing the commit trace to hand values.
module tb_proc_hier_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_we, prog_sel;
  logic [15:0] prog_addr, prog_data;
  logic [15:0] pc, inst;
  logic        reg_write;
  logic [2:0]  write_register;
  logic [15:0] write_data;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_data_in, mem_data_out;
  logic        halt;
  logic        dcache_hit, icache_hit, dcache_req, icache_req;
  logic [31:0] cycle_count;
`ifdef INST_COUNT_EN
  logic [31:0] inst_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  proc_hier_top #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .prog_we(prog_we), .prog_sel(prog_sel),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .pc(pc), .inst(inst),
    .reg_write(reg_write), .write_register(write_register),
    .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out),
    .halt(halt),
    .dcache_hit(dcache_hit), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .icache_req(icache_req),
`ifdef INST_COUNT_EN
    .inst_count(inst_count),
`endif
    .cycle_count(cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pwrite(input logic sel, input logic [15:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_sel = sel; prog_addr = a; prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic clear_imem();
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) pwrite(1'b0, 16'(i), 16'h0000);
  endtask

  task automatic release_reset();
    prog_we = 1'b0;
    rst_n   = 1'b1;
  endtask

  task automatic chk_wr(input string tag, input logic [2:0] r, input logic [15:0] d);
    chk({tag, ".we"}, 32'(reg_write), 32'd1);
    chk({tag, ".wr"}, 32'(write_register), 32'(r));
    chk({tag, ".wd"}, 32'(write_data), 32'(d));
  endtask

  initial begin
    rst_n = 1'b0; prog_we = 1'b0; prog_sel = 1'b0; prog_addr = '0; prog_data = '0;
    step();

    // Test 1: HALT at address 0
    clear_imem();
    pwrite(1'b0, 16'd0, 16'hF000);
    release_reset();
    chk("t1.rst_pc", 32'(pc), 32'h0);
    chk("t1.rst_inst", 32'(inst), 32'h0);
    chk("t1.rst_halt", 32'(halt), 32'h0);
    chk("t1.rst_cyc", cycle_count, 32'd0);
    chk("t1.cache", 32'({dcache_hit, icache_hit, dcache_req, icache_req}), 32'h0);
    step();
    chk("t1.halt", 32'(halt), 32'h1);
    chk("t1.pc", 32'(pc), 32'h0);
    chk("t1.cyc", cycle_count, 32'd1);
    step(); step(); step();
    chk("t1.halt_sticky", 32'(halt), 32'h1);
    chk("t1.cyc_frozen", cycle_count, 32'd1);
    chk("t1.inst_frozen", 32'(inst), 32'hF000);

    // Test 2: ADDI/ADDI/ADD/HALT with back-to-back dependencies
    clear_imem();
    pwrite(1'b0, 16'd0, 16'h5205);
    pwrite(1'b0, 16'd1, 16'h547E);
    pwrite(1'b0, 16'd2, 16'h1650);
    pwrite(1'b0, 16'd3, 16'hF000);
    release_reset();
    step();
    chk("t2.c1.pc", 32'(pc), 32'h0);
    chk_wr("t2.c1", 3'd1, 16'h0005);
    step();
    chk_wr("t2.c2", 3'd2, 16'h0003);
    step();
    chk_wr("t2.c3", 3'd3, 16'h0008);
    chk("t2.c3.mr", 32'(mem_read), 32'h0);
    step();
    chk("t2.halt", 32'(halt), 32'h1);
    chk("t2.halt_pc", 32'(pc), 32'h3);
    chk("t2.halt_we", 32'(reg_write), 32'h0);
    chk("t2.cyc", cycle_count, 32'd4);
    step();
    chk("t2.cyc_frozen", cycle_count, 32'd4);
`ifdef INST_COUNT_EN
    chk("t2.icount", inst_count, 32'd4);
    step();
    chk("t2.icount_once", inst_count, 32'd4);
`endif

    // Test 3: store then load through memory
    clear_imem();
    pwrite(1'b1, 16'h0011, 16'hDEAD);
    pwrite(1'b0, 16'd0, 16'h5210);
    pwrite(1'b0, 16'd1, 16'h5407);
    pwrite(1'b0, 16'd2, 16'h7441);
    pwrite(1'b0, 16'd3, 16'h6841);
    pwrite(1'b0, 16'd4, 16'hF000);
    release_reset();
    step();
    chk_wr("t3.c1", 3'd1, 16'h0010);
    chk("t3.c1.maddr", 32'(mem_address), 32'h0);
    step();
    chk_wr("t3.c2", 3'd2, 16'h0007);
    step();
    chk("t3.st.mw", 32'(mem_write), 32'h1);
    chk("t3.st.mr", 32'(mem_read), 32'h0);
    chk("t3.st.addr", 32'(mem_address), 32'h0011);
    chk("t3.st.din", 32'(mem_data_in), 32'h0007);
    chk("t3.st.we", 32'(reg_write), 32'h0);
    chk("t3.st.wd", 32'(write_data), 32'h0);
    step();
    chk("t3.ld.mr", 32'(mem_read), 32'h1);
    chk("t3.ld.mw", 32'(mem_write), 32'h0);
    chk("t3.ld.addr", 32'(mem_address), 32'h0011);
    chk("t3.ld.dout", 32'(mem_data_out), 32'h0007);
    chk("t3.ld.din", 32'(mem_data_in), 32'h0);
    chk_wr("t3.ld", 3'd4, 16'h0007);
    step();
    chk("t3.halt_pc", 32'(pc), 32'h4);

    // Test 4: taken BEQZ R0,+2 squashes slots 1 and 2
    clear_imem();
    pwrite(1'b0, 16'd0, 16'h8002);
    pwrite(1'b0, 16'd1, 16'h5A01);
    pwrite(1'b0, 16'd2, 16'h5A02);
    pwrite(1'b0, 16'd3, 16'h5C09);
    pwrite(1'b0, 16'd4, 16'hF000);
    release_reset();
    step();
    chk("t4.br.inst", 32'(inst), 32'h8002);
    chk("t4.br.we", 32'(reg_write), 32'h0);
    step();
    chk("t4.bub.inst", 32'(inst), 32'h0000);
    chk("t4.bub.pc", 32'(pc), 32'h2);
    chk("t4.bub.we", 32'(reg_write), 32'h0);
    step();
    chk("t4.tgt.pc", 32'(pc), 32'h3);
    chk_wr("t4.tgt", 3'd6, 16'h0009);
    step();
    chk("t4.halt_pc", 32'(pc), 32'h4);

    // Test 5: wrap-around, then BEQZ on a register that became zero
    clear_imem();
    pwrite(1'b0, 16'd0, 16'h523F);
    pwrite(1'b0, 16'd1, 16'h5241);
    pwrite(1'b0, 16'd2, 16'h8201);
    pwrite(1'b0, 16'd3, 16'h5E01);
    pwrite(1'b0, 16'd4, 16'hF000);
    release_reset();
    step();
    chk_wr("t5.c1", 3'd1, 16'hFFFF);
    step();
    chk_wr("t5.c2", 3'd1, 16'h0000);
    step();
    chk("t5.br.pc", 32'(pc), 32'h2);
    step();
    chk("t5.bub.inst", 32'(inst), 32'h0000);
    chk("t5.bub.pc", 32'(pc), 32'h3);
    step();
    chk("t5.halt", 32'(halt), 32'h1);
    chk("t5.halt_pc", 32'(pc), 32'h4);

    // Test 6: loop with backward J, reset mid-run, trace restarts
    clear_imem();
    pwrite(1'b0, 16'd0, 16'h5241);
    pwrite(1'b0, 16'd1, 16'h91FE);
    release_reset();
    step();
    chk_wr("t6.c1", 3'd1, 16'h0001);
    step();
    chk("t6.j.inst", 32'(inst), 32'h91FE);
    step();
    chk("t6.bub.pc", 32'(pc), 32'hFFFF);
    step();
    chk_wr("t6.c4", 3'd1, 16'h0002);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6.rst.pc", 32'(pc), 32'h0);
    chk("t6.rst.inst", 32'(inst), 32'h0);
    chk("t6.rst.cyc", cycle_count, 32'd0);
`ifdef INST_COUNT_EN
    chk("t6.rst.icount", inst_count, 32'd0);
`endif
    step();
    chk("t6.r1.pc", 32'(pc), 32'h0);
    chk_wr("t6.r1", 3'd1, 16'h0001);
    step();
    chk("t6.r2.inst", 32'(inst), 32'h91FE);
    step();
    chk("t6.r3.pc", 32'(pc), 32'hFFFF);
    chk("t6.r3.inst", 32'(inst), 32'h0000);
    chk("t6.r3.cyc", cycle_count, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_hier_top.md
Name: proc_hier_top

Overview:
- Self-contained 16-bit, 8-register, two-stage (fetch / execute-commit) processor with internal instruction and data memories.
- Exports a per-cycle commit trace: PC, instruction, register write, memory access and halt.
- Trace ports are sampled by a simulation-logging bench.
- Top-level processor hierarchy; owns the free-running cycle counter.

Parameters:
IMEM_DEPTH, 256, instruction memory words (16-bit, word-addressed, index = PC mod depth)
DMEM_DEPTH, 256, data memory words (16-bit, word-addressed, index = address mod depth)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
prog_we  in  1  program/data load write enable
prog_sel  in  1  0 = load instruction memory, 1 = load data memory
prog_addr  in  16  load address
prog_data  in  16  load data
pc  out  16  PC of instruction in execute stage
inst  out  16  instruction register (fetch flip-flop)
reg_write  out  1  register file written this cycle
write_register  out  3  destination register
write_data  out  16  data written to register
mem_read  out  1  load executing
mem_write  out  1  store executing
mem_address  out  16  load/store address
mem_data_in  out  16  store data
mem_data_out  out  16  load data read
halt  out  1  HALT committed (sticky)
dcache_hit, icache_hit, dcache_req, icache_req  out  1 each  tied 0 (no caches)
cycle_count  out  32  cycles since reset released

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at posedge):
  - fetch PC=0, inst=0x0000 (NOP), execute pc=0
  - R0–R7 = 0, halt=0, cycle_count=0
  - memory contents not reset
- prog_we writes the selected memory at posedge regardless of rst_n. It is intended for use while rst_n=0.
- cycle_count increments every posedge with rst_n=1 and halt=0.
- Pipeline timing:
  - Each cycle the fetch stage reads imem[fPC] (combinational) into inst at posedge and captures fPC into pc.
  - fPC advances by 1 each cycle.
  - The execute stage decodes inst combinationally; all trace outputs reflect it in the same cycle.
  - Register/memory writes occur at the following posedge.
- Encoding: op=[15:12], rd=[11:9], rs=[8:6], rt=[5:3], imm6=[5:0] sign-extended, imm9=[8:0] sign-extended.
- Opcodes:
  - 0x0 NOP
  - 0x1 ADD rd=rs+rt
  - 0x2 SUB rd=rs-rt
  - 0x3 AND
  - 0x4 XOR
  - 0x5 ADDI rd=rs+imm6
  - 0x6 LD rd=dmem[rs+imm6]
  - 0x7 ST dmem[rs+imm6]=rd
  - 0x8 BEQZ: if rd==0, PC=pc+1+imm9
  - 0x9 J: PC=pc+1+imm9
  - 0xF HALT
  - others = NOP
- Arithmetic is modulo 2^16, with no flags.
- All registers are general; R0 is not hardwired.
- Register read after write: write-back completes at the posedge, so a dependent instruction in the next cycle reads the new value. The register file is write-then-read, with no hazard stall.
- Taken BEQZ/J:
  - fPC redirected at the posedge
  - the already-fetched instruction is squashed: inst loads 0x0000 and pc loads the target-1 slot PC
  - one bubble cycle
- Trace outputs when inactive:
  - reg_write=1 only for ADD/SUB/AND/XOR/ADDI/LD
  - when inactive, write_register/write_data/mem_* are 0
  - mem_address is valid on LD/ST; mem_data_out is valid on LD; mem_data_in is valid on ST
- HALT:
  - halt goes 1 in the cycle HALT is in execute and stays 1
  - PC, inst, registers, memories and cycle_count freeze until reset

Optional Feature:
- Macro INST_COUNT_EN.
- When defined, adds output inst_count (32-bit), reset to 0.
- inst_count increments at each posedge (rst_n=1) where halt-commit, reg_write or mem_write is 1. HALT counts once only.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then run: imem all NOP except [0]=HALT → halt=1 in cycle 1 with pc=0; cycle_count frozen at 1 afterwards.
- ADDI R1,R0,5; ADDI R2,R1,-2; ADD R3,R1,R2; HALT → trace shows:
  - R1=0x0005, R2=0x0003, R3=0x0008 in consecutive cycles
  - halt at pc=3
- ST/LD: ADDI R1,R0,0x10; ADDI R2,R0,7; ST R2,[R1+1]; LD R4,[R1+1] → cycle-by-cycle trace:
  - ST cycle: mem_write=1, mem_address=0x0011, mem_data_in=0x0007
  - LD cycle: mem_read=1, mem_data_out=0x0007, R4=0x0007
- Branch: BEQZ R0,+2 at pc=0 → one squashed cycle with inst=0x0000, then pc=3; instructions at 1–2 never commit.
- Wrap-around: ADDI R1,R0,-1; ADDI R1,R1,1 → R1=0xFFFF then 0x0000.
- Reset mid-run: deassert rst_n for one posedge after 5 cycles → the following cycles match the trace of a fresh run from pc=0. With INST_COUNT_EN defined, inst_count=0 after the reset.
